// File: rtl/ssc_host_pkg.sv
// Shared definitions for the sample-stream host.
// Holds the bus/sample widths, the bus FSM state type and a saturating
// increment used by the underrun counter.
package ssc_host_pkg;

  localparam int unsigned BusW = 32;
  localparam int unsigned SmpW = 16;
  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StRsp
  } bus_state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == {CntW{1'b1}}) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-in first-out buffer for ADC samples.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   wr_en_i, wdata_i   push request and data (ignored when full)
//   rd_en_i, rdata_o   pop request (ignored when empty); rdata_o shows the head
//   full_o, empty_o    registered occupancy flags
//   count_o            current number of stored entries
module sample_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       rd_en_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Storage carries no reset; only pointers and occupancy are state.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ssc_host.sv
// Host bridge: turns valid/ready host commands into one-cycle register bus
// strobes toward the analyzer, and paces a buffered sample stream into the
// analyzer at one push opportunity every ADC_DIV clocks.
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata   host command channel
//   rsp_valid/rsp_ready/rsp_data     read response channel
//   addr/Wdata/write/read/Rdata      register bus to analyzer
//   smp_valid/smp_ready/smp_data     incoming sample stream
//   ADC/pushADC                      sample push to analyzer
//   underrun_cnt                     saturating count of missed push slots
module ssc_host
  import ssc_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADC_DIV    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [BusW-1:0] cmd_addr,
  input  logic [BusW-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [BusW-1:0] rsp_data,
  output logic [BusW-1:0] addr,
  output logic [BusW-1:0] Wdata,
  output logic            write,
  output logic            read,
  input  logic [BusW-1:0] Rdata,
  input  logic            smp_valid,
  output logic            smp_ready,
  input  logic [SmpW-1:0] smp_data,
  output logic [SmpW-1:0] ADC,
  output logic            pushADC,
  output logic [CntW-1:0] underrun_cnt
);

  localparam int unsigned DivW = (ADC_DIV > 1) ? $clog2(ADC_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ADC_DIV - 1);

  // ---------------------------------------------------------------------------
  // Register bus FSM
  // ---------------------------------------------------------------------------
  bus_state_e      state_q;
  logic [BusW-1:0] addr_q, wdata_q, rsp_data_q;
  logic            write_q, read_q, rsp_valid_q;

  // Gated by rst so the host sees no acceptance while reset is held.
  assign cmd_ready = rst && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            write_q <= cmd_write;
            read_q  <= !cmd_write;
            state_q <= cmd_write ? StWr : StRd;
          end
        end
        StWr: begin
          write_q <= 1'b0;
          state_q <= StIdle;
        end
        StRd: begin
          // Analyzer returns Rdata combinationally during the read cycle.
          read_q      <= 1'b0;
          rsp_data_q  <= Rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= StRsp;
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr      = addr_q;
  assign Wdata     = wdata_q;
  assign write     = write_q;
  assign read      = read_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // ---------------------------------------------------------------------------
  // Sample path
  // ---------------------------------------------------------------------------
  logic [SmpW-1:0]             fifo_rdata;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_wr, pop, tick;

  logic [DivW-1:0] div_q;
  logic [SmpW-1:0] adc_q;
  logic            push_q;
  logic [CntW-1:0] underrun_q;

  assign smp_ready = rst && !fifo_full;
  assign fifo_wr   = smp_valid && smp_ready;
  assign tick      = (div_q == DivLast);
  assign pop       = tick && !fifo_empty;

  sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (SmpW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .wr_en_i (fifo_wr),
    .wdata_i (smp_data),
    .rd_en_i (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      adc_q      <= '0;
      push_q     <= 1'b0;
      underrun_q <= '0;
    end else begin
      div_q  <= tick ? '0 : div_q + DivW'(1);
      push_q <= pop;
      if (pop) begin
        adc_q <= fifo_rdata;
      end
      if (tick && fifo_empty) begin
        underrun_q <= sat_inc(underrun_q);
      end
    end
  end

  assign ADC          = adc_q;
  assign pushADC      = push_q;
  assign underrun_cnt = underrun_q;

  // Structural invariants of the bridge.
  assert property (@(posedge clk) disable iff (!rst) !(write && read));
  assert property (@(posedge clk) disable iff (!rst)
                   fifo_count <= ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_ssc_host.sv
// Directed bench for ssc_host with default parameters (FIFO_DEPTH=4, ADC_DIV=4).
module tb_ssc_host;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data, addr, Wdata, Rdata = '0;
  logic        write, read;
  logic        smp_valid = 1'b0, smp_ready;
  logic [15:0] smp_data = '0, ADC, underrun_cnt;
  logic        pushADC;

  int n_checks = 0;
  int n_fail   = 0;

  ssc_host #(
    .FIFO_DEPTH (4),
    .ADC_DIV    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .addr         (addr),
    .Wdata        (Wdata),
    .write        (write),
    .read         (read),
    .Rdata        (Rdata),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .smp_data     (smp_data),
    .ADC          (ADC),
    .pushADC      (pushADC),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] smp_tab [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
  bit          exp_wr  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  bit          exp_rd  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  bit          exp_rv  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit          b2b_wr  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] b2b_ad  [3] = '{32'h30, 32'h34, 32'h38};

  initial begin
    int  sent;
    int  idx;
    bit  hs;

    // Reset state
    repeat (3) step();
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_wdata", Wdata, 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_read", 32'(read), 32'd0);
    check_eq("rst_adc", 32'(ADC), 32'd0);
    check_eq("rst_push", 32'(pushADC), 32'd0);
    check_eq("rst_smp_ready", 32'(smp_ready), 32'd0);
    check_eq("rst_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: no samples for 3 ticks (ticks on every 4th edge)
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check_eq("ur_push", 32'(pushADC), 32'd0);
      check_eq("ur_cnt", 32'(underrun_cnt), 32'(i / 4));
      check_eq("ur_adc", 32'(ADC), 32'd0);
    end

    // Stream 1..5: pushes on edges 4,8,12,16,20; FIFO fills after edge 5
    sent = 0;
    for (int c = 1; c <= 20; c++) begin
      if (sent < 5) begin
        smp_valid = 1'b1;
        smp_data  = smp_tab[sent];
      end else begin
        smp_valid = 1'b0;
      end
      hs = smp_valid && smp_ready;
      step();
      if (hs) sent++;
      check_eq("st_push", 32'(pushADC), (c % 4 == 0) ? 32'd1 : 32'd0);
      check_eq("st_adc", 32'(ADC), 32'(c / 4));
      if (c == 4) check_eq("st_ready_c4", 32'(smp_ready), 32'd1);
      if (c == 5) check_eq("st_ready_full", 32'(smp_ready), 32'd0);
      if (c == 8) check_eq("st_ready_c8", 32'(smp_ready), 32'd1);
    end
    smp_valid = 1'b0;
    check_eq("st_underrun", 32'(underrun_cnt), 32'd3);

    // Write command
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
    check_eq("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    check_eq("wr_write", 32'(write), 32'd1);
    check_eq("wr_read", 32'(read), 32'd0);
    check_eq("wr_addr", addr, 32'h10);
    check_eq("wr_wdata", Wdata, 32'hDEADBEEF);
    check_eq("wr_busy", 32'(cmd_ready), 32'd0);
    step();
    check_eq("wr_done", 32'(write), 32'd0);
    check_eq("wr_idle", 32'(cmd_ready), 32'd1);
    check_eq("wr_addr_hold", addr, 32'h10);

    // Read command with response held off for 5 cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    step();
    cmd_valid = 1'b0;
    check_eq("rd_read", 32'(read), 32'd1);
    check_eq("rd_write", 32'(write), 32'd0);
    check_eq("rd_addr", addr, 32'h20);
    check_eq("rd_rv_early", 32'(rsp_valid), 32'd0);
    Rdata = 32'h12345678;
    step();
    Rdata = 32'hFFFFFFFF;
    check_eq("rd_read_done", 32'(read), 32'd0);
    check_eq("rd_rv", 32'(rsp_valid), 32'd1);
    check_eq("rd_data", rsp_data, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("rd_hold_rv", 32'(rsp_valid), 32'd1);
      check_eq("rd_hold_data", rsp_data, 32'h12345678);
      check_eq("rd_hold_busy", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("rd_rv_clr", 32'(rsp_valid), 32'd0);
    check_eq("rd_idle", 32'(cmd_ready), 32'd1);

    // Reset during RD aborts the transaction
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
    step();
    cmd_valid = 1'b0;
    check_eq("ra_read", 32'(read), 32'd1);
    rst = 1'b0;
    step();
    check_eq("ra_read_clr", 32'(read), 32'd0);
    check_eq("ra_rv", 32'(rsp_valid), 32'd0);
    check_eq("ra_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("ra_smp_ready", 32'(smp_ready), 32'd0);
    check_eq("ra_underrun", 32'(underrun_cnt), 32'd0);
    check_eq("ra_addr", addr, 32'd0);
    rst = 1'b1;
    step();
    check_eq("ra_cmd_ready_back", 32'(cmd_ready), 32'd1);
    check_eq("ra_rv_after", 32'(rsp_valid), 32'd0);
    check_eq("ra_read_after", 32'(read), 32'd0);

    // Back-to-back commands held valid: W 0x30, R 0x34, W 0x38
    idx = 0;
    Rdata = 32'hA5A5A5A5;
    rsp_ready = 1'b1;
    for (int e = 0; e < 7; e++) begin
      if (idx < 3) begin
        cmd_valid = 1'b1;
        cmd_write = b2b_wr[idx];
        cmd_addr  = b2b_ad[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      hs = cmd_valid && cmd_ready;
      step();
      if (hs) idx++;
      check_eq("bb_write", 32'(write), 32'(exp_wr[e]));
      check_eq("bb_read", 32'(read), 32'(exp_rd[e]));
      check_eq("bb_rsp_valid", 32'(rsp_valid), 32'(exp_rv[e]));
      check_eq("bb_overlap", 32'(write && read), 32'd0);
      if (e == 3) check_eq("bb_rsp_data", rsp_data, 32'hA5A5A5A5);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check_eq("bb_last_addr", addr, 32'h38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssc_host.md
SSC_HOST -- requirements
Module: ssc_host

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, ADC sample FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ADC_DIV, default 4, clocks between ADC push opportunities (>=1).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  host command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when both high.
REQ-007 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  in  32  register address.
REQ-009 SHALL have port cmd_wdata  in  32  write data.
REQ-010 SHALL have port rsp_valid  out  1  read data available.
REQ-011 SHALL have port rsp_ready  in  1  host consumes rsp_data.
REQ-012 SHALL have port rsp_data  out  32  captured read data.
REQ-013 SHALL have ports addr out 32, Wdata out 32, write out 1, read out 1, Rdata in 32: register bus to analyzer.
REQ-014 SHALL have ports smp_valid in 1, smp_ready out 1, smp_data in 16: sample input stream.
REQ-015 SHALL have ports ADC out 16, pushADC out 1: sample push to analyzer.
REQ-016 SHALL have port underrun_cnt  out  16  push opportunities missed due to empty FIFO.

Function
REQ-017 Bus FSM SHALL have states IDLE, WR, RD, RSP; cmd_ready = (state==IDLE) and not in reset.
REQ-018 On accept in IDLE: latch addr/wdata; go WR if cmd_write else RD.
REQ-019 WR SHALL drive write=1, addr, Wdata for exactly one cycle, then IDLE.
REQ-020 RD SHALL drive read=1, addr for exactly one cycle; Rdata sampled at end of that cycle into rsp_data; next state RSP.
REQ-021 RSP SHALL hold rsp_valid=1 and rsp_data stable until rsp_ready=1 seen, then IDLE.
REQ-022 Latency: write on bus cycle N+1 after accept cycle N; rsp_valid from cycle N+2.
REQ-023 write and read SHALL never be high together; both low outside WR/RD; addr/Wdata hold last value.
REQ-024 Sample FIFO: smp_ready = not full (registered state); write when smp_valid&&smp_ready.
REQ-025 Divider counter SHALL count 0..ADC_DIV-1 and wrap; tick when count==ADC_DIV-1.
REQ-026 On tick with FIFO non-empty: pop head to ADC and pushADC=1 for one cycle, registered.
REQ-027 On tick with FIFO empty: no push; underrun_cnt increments, saturating at 0xFFFF.
REQ-028 Simultaneous FIFO write and pop SHALL both occur; occupancy unchanged; at full no write (smp_ready low).
REQ-029 FIFO order SHALL be strict first-in first-out, pointer wrap at FIFO_DEPTH.
REQ-030 ADC SHALL hold last pushed value while pushADC low.

Reset
REQ-031 While rst=0 at clk edge: FSM->IDLE, FIFO empty, divider=0, underrun_cnt=0.
REQ-032 Reset outputs: cmd_ready=0, rsp_valid=0, rsp_data=0, addr=0, Wdata=0, write=0, read=0, ADC=0, pushADC=0, smp_ready=0.
REQ-033 Reset mid-transaction SHALL abort it; no bus strobe and no pending response after reset.

Structure
REQ-034 Package ssc_host_pkg SHALL hold FSM state enum, bus widths (32), sample width (16).
REQ-035 FIFO SHALL be sub-module sample_fifo (parameter depth/width, full/empty, count).

Verification
REQ-036 Write cmd addr=0x10, wdata=0xDEADBEEF -> write=1 exactly one cycle after accept with those values; no read.
REQ-037 Read cmd addr=0x20, Rdata=0x12345678 during read cycle -> rsp_valid two cycles after accept, rsp_data=0x12345678, held while rsp_ready=0 for 5 cycles.
REQ-038 Stream samples 1,2,3,4,5 with ADC_DIV=4 -> pushADC every 4 clocks, ADC=1..5 in order, smp_ready low when 4 buffered.
REQ-039 No samples for 3 ticks -> underrun_cnt=3, pushADC stays 0, ADC unchanged.
REQ-040 Reset asserted during RD -> read=0, rsp_valid=0 after edge; cmd_ready=1 cycle after rst returns high.
REQ-041 Back-to-back commands held valid -> each accepted only in IDLE; write/read never overlap.
